// File: rtl/mem_burst_if.sv
// Bus bundle for mem_burst_master: command, write-data stream, read-data stream,
// memory request port and status. The master modport is the burst engine's view.
interface mem_burst_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ADDR  = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_wr;
  logic [ADDR-1:0]  cmd_addr;
  logic [ADDR:0]    cmd_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic             rd_last;
  logic [ADDR-1:0]  mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_wrbar;
  logic             mem_valid;
  logic             mem_ready;
  logic [WIDTH-1:0] mem_rdata;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
           mem_ready, mem_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, mem_addr, mem_wdata,
           mem_wrbar, mem_valid, busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
           mem_ready, mem_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, mem_addr, mem_wdata,
           mem_wrbar, mem_valid, busy, done, err
  );
endinterface

// File: rtl/mem_burst_master.sv
// mem_burst_master: turns burst commands into one memory access per beat.
// Write beats are pulled from the wr stream, read beats pushed to the rd stream.
// Optional feature macro: MEM_TIMEOUT_EN (per-beat mem_ready timeout, aborts burst).
module mem_burst_master #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR    = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  mem_burst_if.master  bus
);
  localparam int unsigned LW = ADDR + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Elaboration-time sanity check of the configuration
  if (DEPTH != (32'd1 << ADDR) || TIMEOUT == 0) begin : g_cfg_check
    $error("mem_burst_master: DEPTH must equal 2**ADDR and TIMEOUT must be nonzero");
  end

  logic [2:0]       state_q, state_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [LW-1:0]    rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rd_last_q, rd_last_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             wr_ready_q, wr_ready_d;
  logic             mem_valid_q, mem_valid_d;
  logic             rd_valid_q, rd_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             reject;
  logic             abort;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rd_last_d = rd_last_q;
    reject    = 1'b0;
    abort     = 1'b0;
`ifdef MEM_TIMEOUT_EN
    tmo_d     = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          if (bus.cmd_len == '0 || bus.cmd_len > LW'(DEPTH)) begin
            reject  = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d  = bus.cmd_addr;
            rem_d   = bus.cmd_len;
            dir_d   = bus.cmd_wr;
            state_d = bus.cmd_wr ? S_FETCH : S_REQ;
          end
        end
      end
      S_FETCH: begin
        if (bus.wr_valid && wr_ready_q) begin
          wdata_d = bus.wr_data;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_valid_q && bus.mem_ready) begin
          rem_d  = rem_q - LW'(1);
          addr_d = addr_q + ADDR'(1);
          if (dir_q) begin
            state_d = (rem_d == '0) ? S_DONE : S_FETCH;
          end else begin
            rdata_d   = bus.mem_rdata;
            rd_last_d = (rem_d == '0);
            state_d   = S_RESP;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      S_RESP: begin
        if (bus.rd_ready && rd_valid_q) begin
          rd_last_d = 1'b0;
          state_d   = (rem_q == '0) ? S_DONE : S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    wr_ready_d  = (state_d == S_FETCH);
    mem_valid_d = (state_d == S_REQ);
    rd_valid_d  = (state_d == S_RESP);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_DONE) && (reject || abort);
    // A rejected command never raises busy
    busy_d      = (state_d != S_IDLE) && !reject;
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      dir_q       <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rd_last_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      dir_q       <= dir_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rd_last_q   <= rd_last_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      mem_valid_q <= mem_valid_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Per-beat wait counter, cleared whenever not stalled in REQ
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rdata_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wrbar = dir_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural single-port memory stub.
// Build with +define+MEM_TIMEOUT_EN to include the timeout scenario.
module tb_mem_burst_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_burst_if #(.WIDTH(32), .ADDR(8)) bus ();

  mem_burst_master #(.WIDTH(32), .DEPTH(256), .ADDR(8), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Memory stub state
  logic [31:0] mem [0:255];
  logic [7:0]  wlog [0:1023];
  int          wr_cnt   = 0;
  int          mv_cyc   = 0;
  int          unstable = 0;
  int          lat_cnt  = 0;
  int          stub_lat = 0;
  bit          stub_hold = 1'b0;
  logic        prev_pend = 1'b0;
  logic        prev_hs   = 1'b0;
  logic [7:0]  prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  logic        prev_wrbar = 1'b0;

  logic [31:0] wq    [0:255];
  logic [31:0] exp_q [0:255];
  logic [31:0] wdat1 [0:31];

  assign bus.mem_ready = bus.mem_valid && !stub_hold && (lat_cnt >= stub_lat);
  assign bus.mem_rdata = bus.mem_ready ? mem[bus.mem_addr] : 32'h0;

  // Memory stub: completes requests, logs writes, watches request stability
  always @(posedge clk) begin
    if (bus.mem_valid) begin
      mv_cyc <= mv_cyc + 1;
      if (prev_pend && (bus.mem_addr !== prev_addr || bus.mem_wdata !== prev_wdata ||
                        bus.mem_wrbar !== prev_wrbar))
        unstable <= unstable + 1;
      if (prev_hs) unstable <= unstable + 1;
    end
    prev_pend  <= bus.mem_valid && !bus.mem_ready;
    prev_hs    <= bus.mem_valid && bus.mem_ready;
    prev_addr  <= bus.mem_addr;
    prev_wdata <= bus.mem_wdata;
    prev_wrbar <= bus.mem_wrbar;
    if (bus.mem_valid && bus.mem_ready) begin
      lat_cnt <= 0;
      if (bus.mem_wrbar) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        wlog[wr_cnt]      <= bus.mem_addr;
        wr_cnt            <= wr_cnt + 1;
      end
    end else if (bus.mem_valid) begin
      lat_cnt <= lat_cnt + 1;
    end else begin
      lat_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    check({tag, "_done"},      64'(bus.done),      64'd0);
    check({tag, "_err"},       64'(bus.err),       64'd0);
    check({tag, "_mem_valid"}, 64'(bus.mem_valid), 64'd0);
    check({tag, "_wr_ready"},  64'(bus.wr_ready),  64'd0);
    check({tag, "_rd_valid"},  64'(bus.rd_valid),  64'd0);
    check({tag, "_rd_last"},   64'(bus.rd_last),   64'd0);
    check({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, "_mem_wrbar"}, 64'(bus.mem_wrbar), 64'd0);
    check({tag, "_rd_data"},   64'(bus.rd_data),   64'd0);
  endtask

  // Offer a command; returns at the negedge just after acceptance
  task automatic cmd(input logic w, input logic [7:0] a, input logic [8:0] l);
    int t;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = w;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    t = 0;
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("cmd_accept", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic feed(input logic [31:0] d, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    t = 0;
    while (!bus.wr_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("wr_accept", 64'(bus.wr_ready), 64'd1);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.wr_data  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_done(input logic e, input string tag);
    int t;
    t = 0;
    while (!bus.done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_err"},  64'(bus.err),  64'(e));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic write_burst(input logic [7:0] a, input logic [8:0] l, input bit gaps,
                             input string tag);
    cmd(1'b1, a, l);
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    for (int i = 0; i < int'(l); i++) feed(wq[i], gaps ? (i % 3) : 0);
    wait_done(1'b0, tag);
  endtask

  // Read a burst, consuming with rd_ready high once every `pace` cycles
  task automatic read_burst(input logic [7:0] a, input logic [8:0] l, input int pace,
                            input string tag);
    int n;
    int c;
    cmd(1'b0, a, l);
    n = 0;
    c = 0;
    while (n < int'(l) && c < 3000) begin
      bus.rd_ready = (pace <= 1) ? 1'b1 : ((c % pace) == 0);
      if (bus.rd_valid && bus.rd_ready) begin
        check({tag, "_rd_data"}, 64'(bus.rd_data), 64'(exp_q[n]));
        check({tag, "_rd_last"}, 64'(bus.rd_last), 64'(n == int'(l) - 1));
        n++;
      end
      @(negedge clk);
      c++;
    end
    bus.rd_ready = 1'b0;
    check({tag, "_beats"}, 64'(n), 64'(l));
    wait_done(1'b0, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int t;
    int cnt;
    logic [7:0]  t2a [0:3];
    logic [31:0] t2d [0:3];

    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // T1: 32-beat write from 0x00 then read back
    for (int i = 0; i < 32; i++) begin
      wdat1[i] = $urandom;
      wq[i]    = wdat1[i];
      exp_q[i] = wdat1[i];
    end
    write_burst(8'h00, 9'd32, 1'b0, "t1_wr");
    for (int i = 0; i < 32; i++) check("t1_mem", 64'(mem[i]), 64'(wdat1[i]));
    read_burst(8'h00, 9'd32, 1, "t1_rd");

    // T2: write across the address wrap, then read back in order
    t2a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    t2d = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    for (int i = 0; i < 4; i++) begin
      wq[i]    = t2d[i];
      exp_q[i] = t2d[i];
    end
    base = wr_cnt;
    write_burst(8'hFE, 9'd4, 1'b0, "t2_wr");
    check("t2_wr_count", 64'(wr_cnt - base), 64'd4);
    for (int i = 0; i < 4; i++) check("t2_wr_addr", 64'(wlog[base + i]), 64'(t2a[i]));
    read_burst(8'hFE, 9'd4, 1, "t2_rd");
    wdat1[0] = t2d[2];
    wdat1[1] = t2d[3];

    // T3: illegal lengths 0 and 257 are rejected without memory access
    base = mv_cyc;
    cmd(1'b1, 8'h10, 9'd0);
    check("t3a_done", 64'(bus.done), 64'd1);
    check("t3a_err",  64'(bus.err),  64'd1);
    check("t3a_busy", 64'(bus.busy), 64'd0);
    check("t3a_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(negedge clk);
    check("t3a_done_pulse", 64'(bus.done), 64'd0);
    check("t3a_busy2", 64'(bus.busy), 64'd0);
    check("t3a_cmd_ready2", 64'(bus.cmd_ready), 64'd1);
    cmd(1'b0, 8'h20, 9'd257);
    check("t3b_done", 64'(bus.done), 64'd1);
    check("t3b_err",  64'(bus.err),  64'd1);
    check("t3b_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("t3b_done_pulse", 64'(bus.done), 64'd0);
    check("t3b_busy2", 64'(bus.busy), 64'd0);
    check("t3_no_mem_valid", 64'(mv_cyc - base), 64'd0);

    // T4: gapped write and throttled read with a slow memory
    stub_lat = 2;
    for (int i = 0; i < 8; i++) begin
      wq[i]    = 32'hC0DE_0000 + 32'(i);
      exp_q[i] = 32'hC0DE_0000 + 32'(i);
    end
    write_burst(8'h40, 9'd8, 1'b1, "t4_wr");
    read_burst(8'h40, 9'd8, 3, "t4_rd");
    check("t4_mem_stable", 64'(unstable), 64'd0);
    stub_lat = 0;

    // T5: reset after 5 of 16 write beats
    base = wr_cnt;
    cmd(1'b1, 8'h00, 9'd16);
    for (int i = 0; i < 5; i++) feed(32'h5555_0000 + 32'(i), 0);
    t = 0;
    while (!bus.wr_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t5_sixth_fetch", 64'(bus.wr_ready), 64'd1);
    check("t5_addr_at_rst", 64'(bus.mem_addr), 64'd5);
    check("t5_wr_count", 64'(wr_cnt - base), 64'd5);
    rst = 1'b1;
    @(negedge clk);
    check_idle("t5_rst");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) check("t5_new_word", 64'(mem[i]), 64'(32'h5555_0000 + 32'(i)));
    for (int i = 5; i < 16; i++) check("t5_old_word", 64'(mem[i]), 64'(wdat1[i]));

`ifdef MEM_TIMEOUT_EN
    // T6: memory never answers; burst aborts after 64 request cycles
    stub_hold = 1'b1;
    cmd(1'b0, 8'h10, 9'd4);
    cnt = 0;
    while (bus.mem_valid && cnt < 200) begin
      check("t6_no_rd_valid", 64'(bus.rd_valid), 64'd0);
      cnt++;
      @(negedge clk);
    end
    check("t6_req_cycles", 64'(cnt), 64'd64);
    check("t6_done", 64'(bus.done), 64'd1);
    check("t6_err",  64'(bus.err),  64'd1);
    check("t6_rd_valid", 64'(bus.rd_valid), 64'd0);
    stub_hold = 1'b0;
    @(negedge clk);
    check("t6_done_pulse", 64'(bus.done), 64'd0);
    exp_q[0] = 32'h5555_0000;
    read_burst(8'h00, 9'd1, 1, "t6_next");
`else
    cnt = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
